// File: rtl/serial_arith_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : serial_arith_pkg
// Purpose : Shared types and constants for the bit-serial arithmetic blocks.
//           - state_t       : controller states (IDLE / SHIFT / DONE)
//           - DEFAULT_WIDTH : default operand width
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fulladder
// Purpose : Single-bit full-adder cell.
// Ports   : a, b, cin - addend bits and carry-in
//           sum, cout - sum bit and carry-out
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : serial_subtractor
// Purpose : Bit-serial WIDTH-bit subtractor, diff = a - b - bin (mod 2^WIDTH),
//           LSB first, one bit per clock through a single full-adder cell.
//           Subtraction is done as a + ~b + ~bin; borrow-out = ~final carry.
// Ports   : clk, rst       - clock, asynchronous active-high reset
//           start_i        - request, accepted only while busy_o = 0
//           a_i, b_i, bin_i- operands, captured on the accepted start
//           busy_o         - high while bits are being processed
//           done_o         - one-cycle pulse, result valid
//           diff_o, bout_o - difference and borrow-out, held until next start
//           ovf_o          - signed overflow (macro SIGNED_OVF_EN), else 0
// Config  : define SIGNED_OVF_EN to build the signed-overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             ovf_o
);

   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] diff_q;
   logic             carry_q;
   logic             bout_q;

   logic             w_accept;
   logic             w_last;
   logic             w_b_n;
   logic             w_sum;
   logic             w_cout;

   // A start is honoured whenever the engine is not shifting (IDLE or DONE).
   assign w_accept = start_i && (state_q != ST_SHIFT);
   assign w_last   = (cnt_q == c_LAST);
   assign w_b_n    = ~b_sr_q[0];

   fulladder u_fa (
      .a    (a_sr_q[0]),
      .b    (w_b_n),
      .cin  (carry_q),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_SHIFT;
         ST_SHIFT: if (w_last)  state_d = ST_DONE;
         ST_DONE:  state_d = start_i ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_o = (state_q == ST_SHIFT);
      done_o = (state_q == ST_DONE);
   end

   // Datapath: operand shifters, carry flop, result shifter, borrow-out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         diff_q  <= '0;
         carry_q <= 1'b0;
         bout_q  <= 1'b0;
      end else if (w_accept) begin
         cnt_q   <= '0;
         a_sr_q  <= a_i;
         b_sr_q  <= b_i;
         diff_q  <= '0;
         carry_q <= ~bin_i;       // borrow-in enters as inverted carry-in
      end else if (state_q == ST_SHIFT) begin
         cnt_q   <= cnt_q + 1'b1;
         a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
         b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
         diff_q  <= {w_sum, diff_q[WIDTH-1:1]};
         carry_q <= w_cout;
         if (w_last) begin
            bout_q <= ~w_cout;
         end
      end
   end

   assign diff_o = diff_q;
   assign bout_o = bout_q;

`ifdef SIGNED_OVF_EN
   logic ovf_q;

   // On the MSB slice carry_q is the carry into the MSB and w_cout the carry
   // out of it; their XOR is two's-complement overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (w_accept) begin
         ovf_q <= 1'b0;
      end else if ((state_q == ST_SHIFT) && w_last) begin
         ovf_q <= carry_q ^ w_cout;
      end
   end

   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

endmodule : serial_subtractor
`default_nettype wire
